mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the core's single external memory request interface between two requesters.
  - Port 0: instruction fetch.
  - Port 1: the planned load/store unit.
- Round-robin arbitration; one outstanding memory transaction at a time.
- Latches the winner's request, drives the memory interface until data_valid, then returns a response pulse to the owner.
- Sits in cpu_top between Fetch/LSU and the top-level Addr/Data/we/req_valid/data_valid pins; the top owns the Data tri-state.

Parameters:
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, data width.
- TIMEOUT_CYCLES, 16, BUSY cycles before abort; used only with MEM_TIMEOUT_EN; minimum 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0 / req1  input  1  request from fetch / LSU; held until a grant is seen.
- addr0 / addr1  input  ADDR_WIDTH  request address.
- we0 / we1  input  1  write enable; we0 must be 0 (fetch is read-only); a high we0 is ignored.
- wdata1  input  DATA_WIDTH  LSU write data.
- gnt0 / gnt1  output  1  one-cycle pulse: request latched.
- rsp_valid0 / rsp_valid1  output  1  one-cycle pulse: transaction complete.
- rsp_rdata  output  DATA_WIDTH  read data, valid with either rsp_valid.
- rsp_err  output  1  transaction aborted; qualified by rsp_valid.
- mem_addr  output  ADDR_WIDTH  to external Addr.
- mem_wdata  output  DATA_WIDTH  drive value for Data.
- mem_we  output  1  to external we.
- mem_req_valid  output  1  to external req_valid.
- mem_rdata  input  DATA_WIDTH  sampled Data.
- mem_data_valid  input  1  memory completion (read data valid, or write done).

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, state IDLE, last_owner=1 (fetch wins the first contention), timeout counter 0.
  - Reset asserted mid-transaction drops mem_req_valid immediately and produces no response.
- All outputs are registered.
- FSM: IDLE, BUSY.
- IDLE, no request: stay in IDLE.
- IDLE, request present, at the edge:
  - Select the winner:
    - Only one requester active: that one wins.
    - Both active: the requester other than last_owner wins.
  - Latch the winner's addr, we and wdata into mem_addr, mem_we, mem_wdata. For port 0, mem_we=0 and mem_wdata=0.
  - Set mem_req_valid=1.
  - Pulse gnt of the winner for exactly one cycle.
  - Update last_owner and go to BUSY.
- Requester contract: it sees gnt at the next edge and may drop or replace req/payload at that edge. Requests are not sampled in BUSY.
- BUSY:
  - mem_addr, mem_we, mem_wdata and mem_req_valid are held stable.
  - On an edge with mem_data_valid=1:
    - rsp_rdata <= mem_rdata for a read, 0 for a write.
    - Pulse the owner's rsp_valid for one cycle, with rsp_err=0.
    - mem_req_valid <= 0 and return to IDLE.
- Minimum latency: request sampled at edge N; mem_req_valid high from edge N; response pulse from edge N+k, where k≥1 is the first edge with data_valid.
- Back-to-back: a requester still holding req in the cycle after completion is re-arbitrated normally. mem_req_valid is low for at least one cycle between transactions.
- mem_data_valid while IDLE is ignored.
- gnt0/gnt1 and rsp_valid0/rsp_valid1 are never high simultaneously.
- rsp_rdata holds its value until the next response.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without data_valid.
  - When the count reaches TIMEOUT_CYCLES: drop mem_req_valid, pulse the owner's rsp_valid with rsp_err=1 and rsp_rdata=0, return to IDLE.
  - mem_data_valid on the same edge as expiry wins: normal completion, rsp_err=0.
- Not defined: no counter; BUSY waits indefinitely; rsp_err is tied to 0.

Test Plan:
- Single fetch read: req0, addr0=0x10; memory returns data_valid 2 cycles later with mem_rdata=0xDEADBEEF.
  - Expect gnt0 pulse, mem_req_valid high 2 cycles, then rsp_valid0 with rsp_rdata=0xDEADBEEF, mem_we=0.
- LSU write: req1, we1=1, addr1=0x20, wdata1=0x1234.
  - Expect mem_we=1, mem_wdata=0x1234 stable until data_valid, then rsp_valid1 with rsp_rdata=0.
- Contention: req0 and req1 held continuously for 4 transactions.
  - Expect grant order 0,1,0,1, with mem_req_valid low ≥1 cycle between transactions.
- Request while BUSY: req1 raised during a port-0 transaction.
  - Expect no gnt1 until port 0 completes; gnt1 on the edge after rsp_valid0.
- Reset mid-BUSY: drive reset=0 between clock edges.
  - Expect mem_req_valid=0 immediately, no rsp_valid; after release, next request starts normally.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16): no data_valid.
  - Expect rsp_valid0 with rsp_err=1 at BUSY cycle 16.
  - Variant: data_valid exactly at expiry gives rsp_err=0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that shares one external memory request interface between fetch (port 0) and the LSU (port 1).
// Optional MEM_TIMEOUT_EN macro: abort a BUSY transaction after TIMEOUT_CYCLES cycles without mem_data_valid.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rsp_valid0,
  output logic                  rsp_valid1,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_req_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_data_valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_d;
  logic   last_owner, last_owner_d;
  logic   winner;
  logic   done;
  logic   abort;

  logic                  gnt0_d, gnt1_d, rsp_valid0_d, rsp_valid1_d, rsp_err_d;
  logic                  mem_we_d, mem_req_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d, mem_wdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;

  // Fetch is read-only, so its write enable never reaches the bus.
  logic unused_we0;
  assign unused_we0 = we0;

  // Under contention the port that did not own the last transaction wins.
  assign winner = (req0 && req1) ? ~last_owner : req1;
  assign done   = (state == BUSY) && mem_data_valid;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt;

  // The edge that takes the count to TIMEOUT_CYCLES aborts; data_valid on that edge wins.
  assign abort = (state == BUSY) && !mem_data_valid && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else if (!mem_data_valid) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign abort = 1'b0;
`endif

  // NOTE: state and every output are registers, so they update only with non-blocking assignments.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last_owner    <= 1'b1;
      gnt0          <= 1'b0;
      gnt1          <= 1'b0;
      rsp_valid0    <= 1'b0;
      rsp_valid1    <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_we        <= 1'b0;
      mem_req_valid <= 1'b0;
    end else begin
      state         <= state_d;
      last_owner    <= last_owner_d;
      gnt0          <= gnt0_d;
      gnt1          <= gnt1_d;
      rsp_valid0    <= rsp_valid0_d;
      rsp_valid1    <= rsp_valid1_d;
      rsp_rdata     <= rsp_rdata_d;
      rsp_err       <= rsp_err_d;
      mem_addr      <= mem_addr_d;
      mem_wdata     <= mem_wdata_d;
      mem_we        <= mem_we_d;
      mem_req_valid <= mem_req_valid_d;
    end
  end

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state;
    last_owner_d = last_owner;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_d      = BUSY;
          last_owner_d = winner;
        end
      end
      BUSY: begin
        if (done || abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Computes next values of the registered outputs; bus payload holds unless a new grant is issued.
  always_comb begin
    gnt0_d          = 1'b0;
    gnt1_d          = 1'b0;
    rsp_valid0_d    = 1'b0;
    rsp_valid1_d    = 1'b0;
    rsp_err_d       = 1'b0;
    rsp_rdata_d     = rsp_rdata;
    mem_addr_d      = mem_addr;
    mem_wdata_d     = mem_wdata;
    mem_we_d        = mem_we;
    mem_req_valid_d = mem_req_valid;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          mem_addr_d      = winner ? addr1 : addr0;
          mem_we_d        = winner & we1;
          mem_wdata_d     = winner ? wdata1 : '0;
          mem_req_valid_d = 1'b1;
          gnt0_d          = ~winner;
          gnt1_d          = winner;
        end
      end
      BUSY: begin
        if (done || abort) begin
          mem_req_valid_d = 1'b0;
          rsp_valid0_d    = ~last_owner;
          rsp_valid1_d    = last_owner;
          rsp_err_d       = abort;
          rsp_rdata_d     = (abort || mem_we) ? '0 : mem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; define MEM_TIMEOUT_EN to exercise the abort path.
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata1;
  logic          gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err;
  logic [DW-1:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we, mem_req_valid, mem_data_valid;

  int compared = 0;
  int failed   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(rst_n),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .we0(we0), .we1(we1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_req_valid(mem_req_valid), .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata1 = '0; mem_rdata = '0; mem_data_valid = 0;
    step(); step();
    compared++;
    if ({gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err, mem_we, mem_req_valid} !== 7'b0) begin
      failed++; $display("FAIL reset_ctrl: got %b want 0000000", {gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err, mem_we, mem_req_valid});
    end
    compared++;
    if ({rsp_rdata, mem_addr, mem_wdata} !== '0) begin
      failed++; $display("FAIL reset_data: got %h/%h/%h want 0", rsp_rdata, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fetch_read();
    req0 = 1; addr0 = 32'h10; we0 = 1;
    step();
    compared++;
    if ({gnt0, gnt1, mem_req_valid, mem_we} !== 4'b1010) begin
      failed++; $display("FAIL read_grant: got gnt0/gnt1/req/we=%b want 1010", {gnt0, gnt1, mem_req_valid, mem_we});
    end
    compared++;
    if (mem_addr !== 32'h10 || mem_wdata !== 32'h0) begin
      failed++; $display("FAIL read_payload: got addr %h wdata %h want 10/0", mem_addr, mem_wdata);
    end
    req0 = 0; we0 = 0;
    step();
    compared++;
    if ({gnt0, mem_req_valid, rsp_valid0} !== 3'b010) begin
      failed++; $display("FAIL read_wait: got gnt0/req/rsp=%b want 010", {gnt0, mem_req_valid, rsp_valid0});
    end
    mem_data_valid = 1; mem_rdata = 32'hDEADBEEF;
    step();
    compared++;
    if ({rsp_valid0, rsp_valid1, rsp_err, mem_req_valid} !== 4'b1000 || rsp_rdata !== 32'hDEADBEEF) begin
      failed++; $display("FAIL read_rsp: got v0/v1/err/req=%b rdata %h want 1000 deadbeef", {rsp_valid0, rsp_valid1, rsp_err, mem_req_valid}, rsp_rdata);
    end
    mem_data_valid = 0; mem_rdata = '0;
    step();
    compared++;
    if (rsp_valid0 !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
      failed++; $display("FAIL read_hold: got v0 %b rdata %h want 0 deadbeef", rsp_valid0, rsp_rdata);
    end
  endtask

  task automatic test_lsu_write();
    req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h1234;
    step();
    compared++;
    if ({gnt0, gnt1, mem_req_valid, mem_we} !== 4'b0111 || mem_addr !== 32'h20 || mem_wdata !== 32'h1234) begin
      failed++; $display("FAIL write_grant: got %b addr %h wdata %h want 0111 20 1234", {gnt0, gnt1, mem_req_valid, mem_we}, mem_addr, mem_wdata);
    end
    req1 = 0; we1 = 0; addr1 = 32'hFF; wdata1 = 32'hFFFF;
    step();
    compared++;
    if ({gnt1, mem_req_valid, mem_we} !== 3'b011 || mem_addr !== 32'h20 || mem_wdata !== 32'h1234) begin
      failed++; $display("FAIL write_stable: got %b addr %h wdata %h want 011 20 1234", {gnt1, mem_req_valid, mem_we}, mem_addr, mem_wdata);
    end
    mem_data_valid = 1; mem_rdata = 32'hFFFFFFFF;
    step();
    compared++;
    if ({rsp_valid0, rsp_valid1, rsp_err, mem_req_valid} !== 4'b0100 || rsp_rdata !== 32'h0) begin
      failed++; $display("FAIL write_rsp: got v0/v1/err/req=%b rdata %h want 0100 0", {rsp_valid0, rsp_valid1, rsp_err, mem_req_valid}, rsp_rdata);
    end
    mem_data_valid = 0;
    step();
  endtask

  task automatic test_contention();
    logic [1:0] exp_gnt;
    req0 = 1; req1 = 1; addr0 = 32'h100; addr1 = 32'h200; we1 = 0;
    for (int i = 0; i < 4; i++) begin
      exp_gnt = (i % 2 == 0) ? 2'b10 : 2'b01;
      step();
      compared++;
      if ({gnt0, gnt1} !== exp_gnt || mem_req_valid !== 1'b1 || mem_addr !== (exp_gnt[1] ? 32'h100 : 32'h200)) begin
        failed++; $display("FAIL contention_gnt%0d: got gnt %b req %b addr %h want %b 1", i, {gnt0, gnt1}, mem_req_valid, mem_addr, exp_gnt);
      end
      mem_data_valid = 1; mem_rdata = 32'(i + 1);
      step();
      compared++;
      if ({rsp_valid0, rsp_valid1} !== exp_gnt || mem_req_valid !== 1'b0 || rsp_rdata !== 32'(i + 1)) begin
        failed++; $display("FAIL contention_rsp%0d: got rsp %b req %b rdata %h want %b 0 %0d", i, {rsp_valid0, rsp_valid1}, mem_req_valid, rsp_rdata, exp_gnt, i + 1);
      end
      mem_data_valid = 0;
    end
    req0 = 0; req1 = 0;
    step();
  endtask

  task automatic test_busy_request();
    req0 = 1; addr0 = 32'h30;
    step();
    compared++;
    if ({gnt0, gnt1} !== 2'b10) begin
      failed++; $display("FAIL busy_gnt0: got %b want 10", {gnt0, gnt1});
    end
    req0 = 0; req1 = 1; addr1 = 32'h40; we1 = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      compared++;
      if (gnt1 !== 1'b0 || mem_addr !== 32'h30) begin
        failed++; $display("FAIL busy_no_gnt1_%0d: got gnt1 %b addr %h want 0 30", i, gnt1, mem_addr);
      end
    end
    mem_data_valid = 1; mem_rdata = 32'hA5A5;
    step();
    compared++;
    if ({rsp_valid0, gnt1} !== 2'b10 || rsp_rdata !== 32'hA5A5) begin
      failed++; $display("FAIL busy_rsp0: got rsp0/gnt1 %b rdata %h want 10 a5a5", {rsp_valid0, gnt1}, rsp_rdata);
    end
    mem_data_valid = 0;
    step();
    compared++;
    if ({gnt0, gnt1, mem_req_valid} !== 3'b011 || mem_addr !== 32'h40) begin
      failed++; $display("FAIL busy_gnt1: got gnt/req %b addr %h want 011 40", {gnt0, gnt1, mem_req_valid}, mem_addr);
    end
    req1 = 0;
    mem_data_valid = 1; mem_rdata = 32'h4444;
    step();
    compared++;
    if (rsp_valid1 !== 1'b1 || rsp_rdata !== 32'h4444) begin
      failed++; $display("FAIL busy_rsp1: got v1 %b rdata %h want 1 4444", rsp_valid1, rsp_rdata);
    end
    mem_data_valid = 0;
    step();
  endtask

  task automatic test_reset_mid_busy();
    req0 = 1; addr0 = 32'h50;
    step();
    compared++;
    if ({gnt0, mem_req_valid} !== 2'b11) begin
      failed++; $display("FAIL rstbusy_start: got %b want 11", {gnt0, mem_req_valid});
    end
    req0 = 0;
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({mem_req_valid, gnt0, rsp_valid0} !== 3'b000) begin
      failed++; $display("FAIL rstbusy_async: got req/gnt0/rsp0 %b want 000", {mem_req_valid, gnt0, rsp_valid0});
    end
    mem_data_valid = 1; mem_rdata = 32'h9999;
    step();
    compared++;
    if ({rsp_valid0, rsp_valid1, mem_req_valid} !== 3'b000) begin
      failed++; $display("FAIL rstbusy_norsp: got %b want 000", {rsp_valid0, rsp_valid1, mem_req_valid});
    end
    rst_n = 1'b1; mem_data_valid = 0;
    step();
    req0 = 1; req1 = 1; addr0 = 32'h60; addr1 = 32'h70;
    step();
    compared++;
    if ({gnt0, gnt1, mem_req_valid} !== 3'b101 || mem_addr !== 32'h60) begin
      failed++; $display("FAIL rstbusy_restart: got %b addr %h want 101 60", {gnt0, gnt1, mem_req_valid}, mem_addr);
    end
    req0 = 0; req1 = 0;
    mem_data_valid = 1; mem_rdata = 32'h55550000;
    step();
    compared++;
    if (rsp_valid0 !== 1'b1 || rsp_rdata !== 32'h55550000) begin
      failed++; $display("FAIL rstbusy_rsp: got v0 %b rdata %h want 1 55550000", rsp_valid0, rsp_rdata);
    end
    mem_data_valid = 0;
    step();
  endtask

  task automatic test_idle_data_valid();
    mem_data_valid = 1; mem_rdata = 32'h77;
    for (int i = 0; i < 2; i++) begin
      step();
      compared++;
      if ({rsp_valid0, rsp_valid1, mem_req_valid} !== 3'b000 || rsp_rdata !== 32'h55550000) begin
        failed++; $display("FAIL idle_dv%0d: got %b rdata %h want 000 55550000", i, {rsp_valid0, rsp_valid1, mem_req_valid}, rsp_rdata);
      end
    end
    mem_data_valid = 0;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    req0 = 1; addr0 = 32'h80;
    step();
    req0 = 0;
    for (int k = 1; k < 16; k++) begin
      step();
      compared++;
      if ({rsp_valid0, mem_req_valid} !== 2'b01) begin
        failed++; $display("FAIL tmo_wait%0d: got rsp0/req %b want 01", k, {rsp_valid0, mem_req_valid});
      end
    end
    step();
    compared++;
    if ({rsp_valid0, rsp_err, mem_req_valid} !== 3'b110 || rsp_rdata !== 32'h0) begin
      failed++; $display("FAIL tmo_abort: got v0/err/req %b rdata %h want 110 0", {rsp_valid0, rsp_err, mem_req_valid}, rsp_rdata);
    end
    step();
    req1 = 1; addr1 = 32'h90; we1 = 0;
    step();
    req1 = 0;
    for (int k = 1; k < 16; k++) step();
    mem_data_valid = 1; mem_rdata = 32'hCAFE;
    step();
    compared++;
    if ({rsp_valid1, rsp_err, mem_req_valid} !== 3'b100 || rsp_rdata !== 32'hCAFE) begin
      failed++; $display("FAIL tmo_race: got v1/err/req %b rdata %h want 100 cafe", {rsp_valid1, rsp_err, mem_req_valid}, rsp_rdata);
    end
    mem_data_valid = 0;
    step();
  endtask
`else
  task automatic test_no_timeout();
    req0 = 1; addr0 = 32'h80;
    step();
    req0 = 0;
    for (int k = 0; k < 20; k++) step();
    compared++;
    if ({rsp_valid0, rsp_err, mem_req_valid} !== 3'b001) begin
      failed++; $display("FAIL notmo_wait: got v0/err/req %b want 001", {rsp_valid0, rsp_err, mem_req_valid});
    end
    mem_data_valid = 1; mem_rdata = 32'hBEEF;
    step();
    compared++;
    if ({rsp_valid0, rsp_err} !== 2'b10 || rsp_rdata !== 32'hBEEF) begin
      failed++; $display("FAIL notmo_rsp: got v0/err %b rdata %h want 10 beef", {rsp_valid0, rsp_err}, rsp_rdata);
    end
    mem_data_valid = 0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_read();
    test_lsu_write();
    test_contention();
    test_busy_request();
    test_reset_mid_busy();
    test_idle_data_valid();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
